crc_32_multi_req_rr: RTL and testbench

CRC_32_MULTI_REQ_RR -- requirements
Module: CRC_32_MULTI_REQ_RR

---
 rtl/crc_32_multi_req_rr.sv | 137 +++++++++++++
 tb/tb_crc_32_multi_req_rr.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/crc_32_multi_req_rr.sv
// rtl/crc_32_multi_req_rr.sv - round-robin sharing of INST_COUNT CRC-32 engines among REQ_COUNT requesters
// Optional ACCEPT_CNT counter enabled by defining CRC_32_MULTI_REQ_RR_PERF_EN.
module crc_32_multi_req_rr #(
    parameter int REQ_COUNT      = 4,
    parameter int INST_COUNT     = 2,
    parameter int PARALLEL_DEPTH = 4
) (
    input  logic                                  CLK,
    input  logic                                  RST,
    input  logic [REQ_COUNT-1:0]                  REQ_VALID,
    output logic [REQ_COUNT-1:0]                  REQ_READY,
    input  logic [REQ_COUNT-1:0]                  REQ_SOP,
    input  logic [REQ_COUNT*32-1:0]               CRC_IN,
    input  logic [REQ_COUNT*PARALLEL_DEPTH-1:0]   VALID,
    input  logic [REQ_COUNT*PARALLEL_DEPTH*48-1:0] DATA,
    output logic [REQ_COUNT-1:0]                  RSP_VALID,
    output logic [REQ_COUNT*32-1:0]               CRC_OUT
`ifdef CRC_32_MULTI_REQ_RR_PERF_EN
    ,
    output logic [31:0]                           ACCEPT_CNT
`endif
);
    localparam int PTR_W  = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1;
    localparam int CW     = PTR_W + 1;
    localparam int LANE_W = PARALLEL_DEPTH * 48;
    localparam logic [CW-1:0] REQ_N  = CW'(REQ_COUNT);
    localparam logic [CW-1:0] INST_N = CW'(INST_COUNT);
    localparam logic [31:0]   POLY   = 32'h04C11DB7;

    // Lanes are consumed lane 0 first, each lane MSB (bit 47) first; invalid lanes are skipped.
    function automatic logic [31:0] crc_step(input logic [31:0] seed,
                                             input logic [PARALLEL_DEPTH-1:0] vld,
                                             input logic [LANE_W-1:0] dat);
        logic [31:0] c;
        c = seed;
        for (int l = 0; l < PARALLEL_DEPTH; l++) begin
            if (vld[l]) begin
                for (int b = 47; b >= 0; b--) begin
                    c = {c[30:0], 1'b0} ^ ((c[31] ^ dat[l*48+b]) ? POLY : 32'h0);
                end
            end
        end
        return c;
    endfunction

    logic [31:0]               crc_state [REQ_COUNT];
    logic [31:0]               seed_r    [REQ_COUNT];
    logic [PARALLEL_DEPTH-1:0] vld_r     [REQ_COUNT];
    logic [LANE_W-1:0]         dat_r     [REQ_COUNT];
    logic [31:0]               res       [REQ_COUNT];
    logic [REQ_COUNT-1:0]      active;
    logic [REQ_COUNT-1:0]      empty;
    logic [REQ_COUNT-1:0]      grant;
    logic [REQ_COUNT-1:0]      accept;
    logic [PTR_W-1:0]          ptr;
    logic [PTR_W-1:0]          ptr_nxt;
    logic [CW-1:0]             pos;
    logic [CW-1:0]             n_gnt;
    logic [PTR_W-1:0]          eng_sel   [INST_COUNT];
    logic [INST_COUNT-1:0]     eng_used;
    logic [31:0]               eng_res   [INST_COUNT];

    for (genvar i = 0; i < REQ_COUNT; i++) begin : g_req
        assign vld_r[i]  = VALID[i*PARALLEL_DEPTH +: PARALLEL_DEPTH];
        assign dat_r[i]  = DATA[i*LANE_W +: LANE_W];
        assign seed_r[i] = REQ_SOP[i] ? CRC_IN[i*32 +: 32] : crc_state[i];
        assign active[i] = REQ_VALID[i] && (|vld_r[i]);
        assign empty[i]  = REQ_VALID[i] && !(|vld_r[i]);
        assign CRC_OUT[i*32 +: 32] = crc_state[i];
    end

    // Scan from ptr; the j-th granted requester is steered onto engine j.
    always_comb begin
        grant    = '0;
        eng_used = '0;
        ptr_nxt  = ptr;
        n_gnt    = '0;
        pos      = '0;
        for (int j = 0; j < INST_COUNT; j++) eng_sel[j] = '0;
        for (int k = 0; k < REQ_COUNT; k++) begin
            pos = {1'b0, ptr} + CW'(k);
            if (pos >= REQ_N) pos = pos - REQ_N;
            if (active[pos[PTR_W-1:0]] && (n_gnt < INST_N)) begin
                grant[pos[PTR_W-1:0]] = 1'b1;
                for (int j = 0; j < INST_COUNT; j++) begin
                    if (n_gnt == CW'(j)) begin
                        eng_sel[j]  = pos[PTR_W-1:0];
                        eng_used[j] = 1'b1;
                    end
                end
                n_gnt   = n_gnt + CW'(1);
                ptr_nxt = ((pos + CW'(1)) == REQ_N) ? '0 : PTR_W'(pos + CW'(1));
            end
        end
    end

    for (genvar j = 0; j < INST_COUNT; j++) begin : g_eng
        assign eng_res[j] = crc_step(seed_r[eng_sel[j]], vld_r[eng_sel[j]], dat_r[eng_sel[j]]);
    end

    // Empty beats pass their seed straight through; granted beats take their engine's result.
    always_comb begin
        for (int i = 0; i < REQ_COUNT; i++) begin
            res[i] = seed_r[i];
            for (int j = 0; j < INST_COUNT; j++) begin
                if (eng_used[j] && (eng_sel[j] == PTR_W'(i))) res[i] = eng_res[j];
            end
        end
    end

    assign accept    = empty | grant;
    assign REQ_READY = accept & {REQ_COUNT{~RST}};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < REQ_COUNT; i++) crc_state[i] <= '0;
            RSP_VALID <= '0;
            ptr       <= '0;
        end else begin
            for (int i = 0; i < REQ_COUNT; i++) begin
                if (accept[i]) crc_state[i] <= res[i];
            end
            RSP_VALID <= accept;
            if (|grant) ptr <= ptr_nxt;
        end
    end

`ifdef CRC_32_MULTI_REQ_RR_PERF_EN
    logic [32:0] cnt_sum;
    assign cnt_sum = {1'b0, ACCEPT_CNT} + 33'(n_gnt);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) ACCEPT_CNT <= '0;
        else     ACCEPT_CNT <= cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
    end
`endif
endmodule

// File: tb/tb_crc_32_multi_req_rr.sv
// tb/tb_crc_32_multi_req_rr.sv - directed self-checking bench for crc_32_multi_req_rr
module tb_crc_32_multi_req_rr;
    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic [3:0]   REQ_VALID = '0;
    logic [3:0]   REQ_READY;
    logic [3:0]   REQ_SOP = '0;
    logic [127:0] CRC_IN = '0;
    logic [15:0]  VALID = '0;
    logic [767:0] DATA = '0;
    logic [3:0]   RSP_VALID;
    logic [127:0] CRC_OUT;
`ifdef CRC_32_MULTI_REQ_RR_PERF_EN
    logic [31:0]  ACCEPT_CNT;
    logic [31:0]  exp_cnt = '0;
`endif

    crc_32_multi_req_rr #(.REQ_COUNT(4), .INST_COUNT(2), .PARALLEL_DEPTH(4)) dut (
        .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_SOP(REQ_SOP), .CRC_IN(CRC_IN), .VALID(VALID), .DATA(DATA),
        .RSP_VALID(RSP_VALID), .CRC_OUT(CRC_OUT)
`ifdef CRC_32_MULTI_REQ_RR_PERF_EN
        , .ACCEPT_CNT(ACCEPT_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_state [4];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Remainder of (seed*x^len + M*x^32) mod P, by long division over the whole message.
    function automatic logic [31:0] model(input logic [31:0] seed, input logic [3:0] vld,
                                          input logic [191:0] dat);
        logic [223:0] m;
        logic [223:0] d;
        int len;
        m = '0;
        len = 0;
        for (int l = 0; l < 4; l++) begin
            if (vld[l]) begin
                m = (m << 48) | 224'(dat[l*48 +: 48]);
                len += 48;
            end
        end
        d = (224'(seed) << len) ^ (m << 32);
        for (int b = 223; b >= 32; b--) begin
            if (d[b]) d[b-32 +: 33] = d[b-32 +: 33] ^ {1'b1, 32'h04C11DB7};
        end
        return d[31:0];
    endfunction

    function automatic logic [127:0] packed_exp();
        return {exp_state[3], exp_state[2], exp_state[1], exp_state[0]};
    endfunction

    task automatic cycle(input string tag, input logic [3:0] rv, input logic [3:0] sop,
                         input logic [127:0] cin, input logic [15:0] vl,
                         input logic [767:0] dat, input logic [3:0] exp_rdy);
        REQ_VALID = rv;
        REQ_SOP   = sop;
        CRC_IN    = cin;
        VALID     = vl;
        DATA      = dat;
        #2;
        check({tag, "_ready"}, 128'(REQ_READY), 128'(exp_rdy));
        for (int i = 0; i < 4; i++) begin
            if (exp_rdy[i]) begin
                exp_state[i] = model(sop[i] ? cin[i*32 +: 32] : exp_state[i],
                                     vl[i*4 +: 4], dat[i*192 +: 192]);
`ifdef CRC_32_MULTI_REQ_RR_PERF_EN
                if (|vl[i*4 +: 4]) exp_cnt = exp_cnt + 32'd1;
`endif
            end
        end
        @(posedge CLK);
        #1;
        check({tag, "_rsp"}, 128'(RSP_VALID), 128'(exp_rdy));
        check({tag, "_crc"}, CRC_OUT, packed_exp());
`ifdef CRC_32_MULTI_REQ_RR_PERF_EN
        check({tag, "_cnt"}, 128'(ACCEPT_CNT), 128'(exp_cnt));
`endif
    endtask

    logic [767:0] d;
    logic [127:0] cin;

    initial begin
        for (int i = 0; i < 4; i++) exp_state[i] = '0;

        // Reset holds ready low even with everything offered.
        REQ_VALID = '1;
        VALID     = '1;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_ready", 128'(REQ_READY), 128'h0);
        check("rst_rsp", 128'(RSP_VALID), 128'h0);
        check("rst_crc", CRC_OUT, 128'h0);
        RST = 1'b0;
        REQ_VALID = '0;
        @(posedge CLK);
        #1;

        // All four active every cycle: grants alternate {0,1},{2,3}.
        d = '0;
        for (int i = 0; i < 4; i++) d[i*192 +: 48] = 48'(i + 1);
        cycle("rr0", 4'hF, 4'hF, 128'h0, 16'h1111, d, 4'b0011);
        check("hand_x32", 128'(CRC_OUT[31:0]), 128'h04C11DB7);
        check("hand_x33", 128'(CRC_OUT[63:32]), 128'h09823B6E);
        cycle("rr1", 4'hF, 4'hF, 128'h0, 16'h1111, d, 4'b1100);
        cycle("rr2", 4'hF, 4'h0, 128'h0, 16'h1111, d, 4'b0011);
        cycle("rr3", 4'hF, 4'h0, 128'h0, 16'h1111, d, 4'b1100);

        // Empty SOP beat on requester 2 passes the seed through.
        cin = '0;
        cin[95:64] = 32'hFFFF_FFFF;
        cycle("empty2", 4'b0100, 4'b0100, cin, 16'h0, '0, 4'b0100);
        check("empty2_val", 128'(CRC_OUT[95:64]), 128'hFFFF_FFFF);

        // Three back-to-back beats on requester 0, alongside an empty non-SOP beat on 3.
        cin = '0;
        cin[31:0] = 32'hFFFF_FFFF;
        d = '0;
        d[191:0] = {48'hDEADBEEFCAFE, 48'h5A5A5A5A5A5A, 48'hFEDCBA987654, 48'h0123456789AB};
        cycle("b2b0", 4'b1001, 4'b0001, cin, 16'h000F, d, 4'b1001);
        d[191:0] = {48'h111122223333, 48'h0, 48'hA5A5A5A5A5A5, 48'h000000000001};
        cycle("b2b1", 4'b0001, 4'b0000, cin, 16'h0005, d, 4'b0001);
        d[191:0] = {48'h8000_0000_0001, 48'h0, 48'h0, 48'h0};
        cycle("b2b2", 4'b0001, 4'b0000, cin, 16'h0008, d, 4'b0001);

        // Pointer now 1: scan order respects wraparound and skips invalid requesters.
        d = '0;
        for (int i = 0; i < 4; i++) d[i*192 +: 48] = 48'h0F0F_0000_1234 + 48'(i);
        cycle("gap0", 4'b1001, 4'b0000, 128'h0, 16'hF00F, d, 4'b1001);
        cycle("gap1", 4'b0111, 4'b0000, 128'h0, 16'h0FFF, d, 4'b0110);
        cycle("gap2", 4'b0111, 4'b0000, 128'h0, 16'h0FFF, d, 4'b0011);
        cycle("gap3", 4'b0100, 4'b0000, 128'h0, 16'hFFFF, d, 4'b0100);

        // Reset between accept and response discards everything in flight.
        REQ_VALID = 4'hF;
        VALID     = 16'hFFFF;
        #2;
        RST = 1'b1;
        #1;
        check("midrst_ready", 128'(REQ_READY), 128'h0);
        @(posedge CLK);
        #1;
        check("midrst_rsp", 128'(RSP_VALID), 128'h0);
        check("midrst_crc", CRC_OUT, 128'h0);
        RST = 1'b0;
        for (int i = 0; i < 4; i++) exp_state[i] = '0;
`ifdef CRC_32_MULTI_REQ_RR_PERF_EN
        exp_cnt = '0;
`endif
        cycle("postrst", 4'b1110, 4'b0000, 128'h0, 16'hFFF0, d, 4'b0110);

        REQ_VALID = '0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
